// File: rtl/signed_mul_seq.sv
// signed_mul_seq: sequential shift-add multiplier for signed or unsigned operands with valid/ready handshakes
module signed_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nx;
    logic [2*WIDTH-1:0] mcand, acc, acc_nx;
    logic [WIDTH-1:0]   mplier, mag_a, mag_b;
    logic [CW-1:0]      cnt;
    logic               neg, accept, last;

    // state register; reset wins over every handshake
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state and handshake outputs; operands only count while IDLE, out_ready only while DONE
    always_comb begin
        state_nx  = state;
        accept    = in_valid && state == IDLE;
        last      = cnt == CW'(WIDTH - 1);
        state_nx  = state == IDLE ? (in_valid ? CALC : IDLE) :
                    state == CALC ? (last ? DONE : CALC) :
                    (out_ready ? IDLE : DONE);
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
    end

    // operand magnitudes and the next accumulator value for the current multiplier bit
    always_comb begin
        mag_a  = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b  = (sgn && b[WIDTH-1]) ? -b : b;
        acc_nx = mplier[0] ? acc + mcand : acc;
    end

    // datapath: capture magnitudes on accept, one shift-add step per CALC cycle, sign-fix into p on the last step
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            p      <= '0;
        end else if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
        end else if (state == CALC) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) p <= neg ? -acc_nx : acc_nx;
        end
    end
endmodule
